// File: rtl/mem_io_responder.sv
// Responder for the byte-serial RAM bus: byte RAM plus a UART / sim-control window at 0x3xxxx.
// One access per cycle while Sys_rdy is high, read data registered one cycle after the address.
module mem_io_responder #(
  parameter int ADDR_WIDTH    = 32,
  parameter int RAM_ADDR_BITS = 17,
  parameter int TXF_WIDTH     = 3
) (
  input  logic                  Sys_clk,
  input  logic                  Sys_rst_n,
  input  logic                  Sys_rdy,
  input  logic [ADDR_WIDTH-1:0] MCRAM_addr,
  input  logic [7:0]            MCRAM_data,
  input  logic                  MCRAM_wr,
  output logic [7:0]            RAMMC_data,
  output logic                  io_buffer_full,
  output logic [7:0]            TX_data,
  output logic                  TX_valid,
  input  logic                  TX_ready,
  input  logic [7:0]            RX_data,
  input  logic                  RX_valid,
  output logic                  RX_ready,
  output logic                  Sim_halt,
  output logic                  Err_overflow
);

  localparam int                 DEPTH      = 1 << TXF_WIDTH;
  localparam int                 RAM_DEPTH  = 1 << RAM_ADDR_BITS;
  localparam logic [TXF_WIDTH:0] CNT_DEPTH  = (TXF_WIDTH+1)'(DEPTH);
  localparam logic [TXF_WIDTH:0] CNT_NEAR   = (TXF_WIDTH+1)'(DEPTH - 1);
  localparam logic [TXF_WIDTH:0] CNT_ONE    = (TXF_WIDTH+1)'(1);
  localparam logic [TXF_WIDTH-1:0] PTR_ONE  = TXF_WIDTH'(1);

  logic [7:0] ram_q [RAM_DEPTH];
  logic [7:0] txf_q [DEPTH];

  logic [7:0]           rd_q, rd_d;
  logic [TXF_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [TXF_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [TXF_WIDTH:0]   cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic                 ovf_q, ovf_d;
  logic                 halt_q, halt_d;
  logic                 rx_full_q, rx_full_d;
  logic [7:0]           rx_q, rx_d;

  logic [RAM_ADDR_BITS-1:0] ram_idx;
  logic io_sel, off0, off4;
  logic ram_we, push_req, push_ok, tx_pop, rx_pop, rx_cap, halt_set;
  logic unused_addr;

  assign unused_addr = ^MCRAM_addr[ADDR_WIDTH-1:18];

  assign ram_idx = MCRAM_addr[RAM_ADDR_BITS-1:0];
  assign io_sel  = (MCRAM_addr[17:16] == 2'b11);
  assign off0    = (MCRAM_addr[15:0] == 16'h0000);
  assign off4    = (MCRAM_addr[15:0] == 16'h0004);

  assign ram_we   = Sys_rdy && MCRAM_wr && !io_sel;
  assign push_req = Sys_rdy && io_sel && MCRAM_wr && off0;
  assign halt_set = Sys_rdy && io_sel && MCRAM_wr && off4;
  assign rx_pop   = Sys_rdy && io_sel && !MCRAM_wr && off0 && rx_full_q;
  assign tx_pop   = (cnt_q != '0) && TX_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign push_ok  = push_req && ((cnt_q < CNT_DEPTH) || tx_pop);
  assign rx_cap   = RX_valid && !rx_full_q;

  always_comb begin
    rd_d = rd_q;
    if (Sys_rdy) begin
      if (!io_sel) begin
        rd_d = ram_q[ram_idx];
      end else if (MCRAM_wr) begin
        rd_d = 8'h00;
      end else if (off0) begin
        rd_d = rx_full_q ? rx_q : 8'h00;
      end else if (off4) begin
        rd_d = {6'b0, rx_full_q, full_q};
      end else begin
        rd_d = 8'h00;
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (tx_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok && !tx_pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push_ok && tx_pop) cnt_d = cnt_q - CNT_ONE;
    if (push_req && !push_ok) ovf_d = 1'b1;
    // One slot of slack: the controller sees this flag a cycle late.
    full_d = (cnt_d >= CNT_NEAR);
  end

  always_comb begin
    halt_d    = halt_q | halt_set;
    rx_full_d = rx_full_q;
    rx_d      = rx_q;
    if (rx_cap) begin
      rx_full_d = 1'b1;
      rx_d      = RX_data;
    end else if (rx_pop) begin
      rx_full_d = 1'b0;
    end
  end

  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      rd_q      <= 8'h00;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      full_q    <= 1'b0;
      ovf_q     <= 1'b0;
      halt_q    <= 1'b0;
      rx_full_q <= 1'b0;
      rx_q      <= 8'h00;
    end else begin
      rd_q      <= rd_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      halt_q    <= halt_d;
      rx_full_q <= rx_full_d;
      rx_q      <= rx_d;
    end
  end

  // Storage arrays carry no reset so they map onto RAM macros.
  always_ff @(posedge Sys_clk) begin
    if (ram_we) ram_q[ram_idx] <= MCRAM_data;
  end

  always_ff @(posedge Sys_clk) begin
    if (push_ok) txf_q[wr_ptr_q] <= MCRAM_data;
  end

  assign RAMMC_data     = rd_q;
  assign io_buffer_full = full_q;
  assign TX_valid       = (cnt_q != '0);
  assign TX_data        = TX_valid ? txf_q[rd_ptr_q] : 8'h00;
  assign RX_ready       = !rx_full_q;
  assign Sim_halt       = halt_q;
  assign Err_overflow   = ovf_q;

endmodule
